// File: rtl/regfile_wb_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// regfile_wb_scheduler_pkg
// Shared types and default constants for the regfile writeback scheduler.
//   wb_entry_t       : one buffered late result {rd, wdata}
//   *_DEF constants  : default FIFO depth, outstanding-op limit, starve limit
//   reg_busy()       : busy lookup that treats x0 as never busy
// ----------------------------------------------------------------------------
package regfile_wb_scheduler_pkg;

  localparam int FIFO_DEPTH_DEF   = 2;
  localparam int MAX_OUT_DEF      = 4;
  localparam int STARVE_LIMIT_DEF = 8;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] wdata;
  } wb_entry_t;

  // x0 is hardwired zero, so it can never carry a pending late write.
  function automatic logic reg_busy(input logic [31:0] busy, input logic [4:0] r);
    return (r != 5'd0) && busy[r];
  endfunction

endpackage

// File: rtl/regfile_wb_scheduler_chk.sv
// ----------------------------------------------------------------------------
// regfile_wb_scheduler_chk
// Protocol checks for the writeback scheduler.
//   clk, start     : clock, active-low reset (checks disabled in reset)
//   issue_conflict : long-latency issue to a register that is still busy
//   issue_valid    : issue this cycle
//   commit         : late result committed this cycle
//   out_count      : current outstanding late-op count
// ----------------------------------------------------------------------------
module regfile_wb_scheduler_chk #(
  parameter int MAX_OUT = 4
) (
  input logic       clk,
  input logic       start,
  input logic       issue_conflict,
  input logic       issue_valid,
  input logic       commit,
  input logic [2:0] out_count
);

  localparam logic [2:0] MAX_OUT_C = 3'(MAX_OUT);

  a_no_busy_issue: assert property (@(posedge clk) disable iff (!start)
    !issue_conflict);

  a_no_overflow: assert property (@(posedge clk) disable iff (!start)
    !(issue_valid && !commit && (out_count == MAX_OUT_C)));

  a_no_underflow: assert property (@(posedge clk) disable iff (!start)
    !(commit && !issue_valid && (out_count == 3'd0)));

endmodule

// File: rtl/regfile_wb_scheduler_wb_fifo.sv
// ----------------------------------------------------------------------------
// wb_fifo
// Synchronous FIFO of wb_entry_t holding late results waiting for the
// regfile write port. Head is visible combinationally on dout.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request (ignored while full) and entry
//   pop        : remove head (ignored while empty)
//   dout       : current head entry
//   full/empty : occupancy flags
// ----------------------------------------------------------------------------
module wb_fifo
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t din,
  input  logic      pop,
  output wb_entry_t dout,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  wb_entry_t        mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == DEPTH_C);
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign dout      = mem_r[rd_ptr_r];

  // Storage, pointers (wrap naturally since DEPTH is a power of two) and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// ----------------------------------------------------------------------------
// regfile_wb_scheduler
// Shares the single regfile write port between the in-order W stage and a
// late-completion channel, tracks registers with outstanding late writes and
// requests stalls on dependences or when late results cannot drain.
// Optional macro WB_BYPASS_EN: a late result arriving while the buffer is
// empty and the W stage is idle writes the regfile in the same cycle.
//   clk, start               : clock, asynchronous active-low reset
//   pipe_we/rd/wdata         : W-stage write (wins the port when rd != 0)
//   issue_valid/issue_rd     : long-latency op issued in EX
//   late_valid/rd/wdata      : late result offer; late_ready accepts it
//   rs1_d/rs2_d/rd_d/regwrite_d : decode operands for hazard detection
//   rf_we/rf_waddr/rf_wdata  : regfile write port
//   stall_req, issue_block   : to the hazard unit
//   out_count                : issued but not yet committed late ops
// ----------------------------------------------------------------------------
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int MAX_OUT      = MAX_OUT_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        start,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_wdata,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic        late_valid,
  input  logic [4:0]  late_rd,
  input  logic [31:0] late_wdata,
  output logic        late_ready,
  input  logic [4:0]  rs1_d,
  input  logic [4:0]  rs2_d,
  input  logic [4:0]  rd_d,
  input  logic        regwrite_d,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        stall_req,
  output logic        issue_block,
  output logic [2:0]  out_count
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_LIMIT_C = SW'(STARVE_LIMIT);
  localparam logic [2:0]    MAX_OUT_C      = 3'(MAX_OUT);

  logic [31:0]   busy_r;
  logic [31:0]   busy_next_s;
  logic [2:0]    out_count_r;
  logic [2:0]    out_count_next_s;
  logic [SW-1:0] starve_r;
  logic [SW-1:0] starve_next_s;

  wb_entry_t push_entry_s;
  wb_entry_t head_s;
  logic      fifo_full_s;
  logic      fifo_empty_s;
  logic      push_s;
  logic      pop_s;
  logic      w_own_s;
  logic      bypass_s;
  logic      commit_s;
  logic [4:0] commit_rd_s;
  logic      issue_conflict_s;

  assign push_entry_s = '{rd: late_rd, wdata: late_wdata};
  assign late_ready   = !fifo_full_s;
  assign out_count    = out_count_r;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (start),
    .push  (push_s),
    .din   (push_entry_s),
    .pop   (pop_s),
    .dout  (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Port ownership, buffer handshakes and the committing register.
  always_comb begin
    w_own_s = pipe_we && (pipe_rd != 5'd0);
    pop_s   = !fifo_empty_s && !w_own_s;
`ifdef WB_BYPASS_EN
    bypass_s = fifo_empty_s && !w_own_s && late_valid;
`else
    bypass_s = 1'b0;
`endif
    // A bypassed result never enters the buffer.
    push_s      = late_valid && !fifo_full_s && !bypass_s;
    commit_s    = pop_s || bypass_s;
    commit_rd_s = pop_s ? head_s.rd : late_rd;
    // Reissuing to a register that commits this very cycle is legitimate.
    issue_conflict_s = issue_valid && reg_busy(busy_r, issue_rd) &&
                       !(commit_s && (commit_rd_s == issue_rd));
  end

  // Regfile write port mux: W stage first, then buffer head, then bypass.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    if (!start) begin
      rf_we = 1'b0;
    end else if (w_own_s) begin
      rf_we    = 1'b1;
      rf_waddr = pipe_rd;
      rf_wdata = pipe_wdata;
    end else if (!fifo_empty_s) begin
      rf_we    = 1'b1;
      rf_waddr = head_s.rd;
      rf_wdata = head_s.wdata;
    end else if (bypass_s) begin
      rf_we    = 1'b1;
      rf_waddr = late_rd;
      rf_wdata = late_wdata;
    end else begin
      rf_we = 1'b0;
    end
  end

  // Hazard requests to the pipeline control.
  always_comb begin
    stall_req   = start && (reg_busy(busy_r, rs1_d) ||
                            reg_busy(busy_r, rs2_d) ||
                            (regwrite_d && reg_busy(busy_r, rd_d)) ||
                            fifo_full_s ||
                            (starve_r == STARVE_LIMIT_C));
    issue_block = start && ((out_count_r == MAX_OUT_C) ||
                            (issue_valid && reg_busy(busy_r, issue_rd)));
  end

  // Next-state for scoreboard, outstanding count and starvation counter.
  always_comb begin
    busy_next_s = busy_r;
    // Clear first so that a same-cycle issue to the same rd keeps it busy.
    if (commit_s) begin
      busy_next_s[commit_rd_s] = 1'b0;
    end else begin
      busy_next_s = busy_next_s;
    end
    if (issue_valid && (issue_rd != 5'd0)) begin
      busy_next_s[issue_rd] = 1'b1;
    end else begin
      busy_next_s = busy_next_s;
    end

    case ({issue_valid, commit_s})
      2'b10:   out_count_next_s = out_count_r + 3'd1;
      2'b01:   out_count_next_s = out_count_r - 3'd1;
      default: out_count_next_s = out_count_r;
    endcase

    if (fifo_empty_s || pop_s) begin
      starve_next_s = {SW{1'b0}};
    end else if (starve_r != STARVE_LIMIT_C) begin
      starve_next_s = starve_r + SW'(1);
    end else begin
      starve_next_s = starve_r;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      busy_r      <= 32'd0;
      out_count_r <= 3'd0;
      starve_r    <= {SW{1'b0}};
    end else begin
      busy_r      <= busy_next_s;
      out_count_r <= out_count_next_s;
      starve_r    <= starve_next_s;
    end
  end

  regfile_wb_scheduler_chk #(.MAX_OUT(MAX_OUT)) u_chk (
    .clk            (clk),
    .start          (start),
    .issue_conflict (issue_conflict_s),
    .issue_valid    (issue_valid),
    .commit         (commit_s),
    .out_count      (out_count_r)
  );

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// ----------------------------------------------------------------------------
// tb_regfile_wb_scheduler
// Directed scenarios followed by randomized traffic, all checked against a
// queue-based reference model of the writeback scheduler.
// ----------------------------------------------------------------------------
module tb_regfile_wb_scheduler;

  localparam int DEPTH = 2;
  localparam int MAXO  = 4;
  localparam int SLIM  = 8;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        start;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_wdata;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        late_valid;
  logic [4:0]  late_rd;
  logic [31:0] late_wdata;
  logic        late_ready;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic        regwrite_d;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall_req;
  logic        issue_block;
  logic [2:0]  out_count;

  always #5 clk = ~clk;

  regfile_wb_scheduler dut (
    .clk(clk), .start(start),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_wdata(pipe_wdata),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .late_valid(late_valid), .late_rd(late_rd), .late_wdata(late_wdata),
    .late_ready(late_ready),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .regwrite_d(regwrite_d),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .stall_req(stall_req), .issue_block(issue_block), .out_count(out_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: busy set, buffered results, outstanding count, starve.
  typedef struct { int rd; logic [31:0] data; } ent_t;
  bit [31:0] mbusy;
  ent_t      q[$];
  int        mout;
  int        mstarve;
  int        pend[$];   // issued ops whose result the producer has not handed over
  bit        acc;       // late result accepted on the last edge
  bit        held;

  function automatic void model_reset();
    mbusy = '0; q.delete(); mout = 0; mstarve = 0; pend.delete();
  endfunction

  function automatic bit bz(input int r);
    return (r != 0) && mbusy[r];
  endfunction

  task automatic compare();
    bit w, full, byp, we, stall, blk;
    int ea;
    logic [31:0] ed;
    if (!start) model_reset();
    w    = pipe_we && (pipe_rd != 0);
    full = (q.size() == DEPTH);
    byp  = BYP && (q.size() == 0) && !w && late_valid;
    we   = start && (w || (q.size() > 0) || byp);
    if (w) begin ea = pipe_rd; ed = pipe_wdata; end
    else if (q.size() > 0) begin ea = q[0].rd; ed = q[0].data; end
    else begin ea = late_rd; ed = late_wdata; end
    check("rf_we", rf_we, we);
    if (we) begin
      check("rf_waddr", rf_waddr, ea);
      check("rf_wdata", rf_wdata, ed);
    end
    check("late_ready", late_ready, !full);
    stall = start && (bz(rs1_d) || bz(rs2_d) || (regwrite_d && bz(rd_d)) ||
                      full || (mstarve == SLIM));
    check("stall_req", stall_req, stall);
    blk = start && ((mout == MAXO) || (issue_valid && bz(issue_rd)));
    check("issue_block", issue_block, blk);
    check("out_count", out_count, mout);
  endtask

  task automatic advance();
    bit w, full, byp, pop, commit;
    int crd;
    acc = 1'b0;
    if (!start) begin model_reset(); return; end
    w      = pipe_we && (pipe_rd != 0);
    full   = (q.size() == DEPTH);
    byp    = BYP && (q.size() == 0) && !w && late_valid;
    pop    = (q.size() > 0) && !w;
    commit = pop || byp;
    crd    = pop ? q[0].rd : int'(late_rd);
    if ((q.size() == 0) || pop) mstarve = 0;
    else if (mstarve < SLIM) mstarve++;
    if (pop) void'(q.pop_front());
    if (late_valid && !full) begin
      acc = 1'b1;
      if (!byp) q.push_back('{rd: int'(late_rd), data: late_wdata});
      void'(pend.pop_front());
    end
    if (commit) mbusy[crd] = 1'b0;
    if (issue_valid) begin
      if (issue_rd != 0) mbusy[issue_rd] = 1'b1;
      pend.push_back(int'(issue_rd));
      mout++;
    end
    if (commit) mout--;
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    advance();
    held = late_valid && !acc;
    #1;
  endtask

  task automatic idle();
    pipe_we = 0; pipe_rd = 0; pipe_wdata = 0;
    issue_valid = 0; issue_rd = 0;
    late_valid = 0; late_rd = 0; late_wdata = 0;
    rs1_d = 0; rs2_d = 0; rd_d = 0; regwrite_d = 0;
  endtask

  task automatic issue(input int rd);
    issue_valid = 1; issue_rd = 5'(rd);
    step();
    issue_valid = 0;
  endtask

  // Producer offers the oldest pending result and holds it until accepted.
  task automatic send_late(input logic [31:0] d, input int budget);
    late_valid = 1; late_rd = 5'(pend[0]); late_wdata = d;
    for (int n = 0; n < budget; n++) begin
      step();
      if (acc) break;
    end
    check("late_accept", acc, 1'b1);
    late_valid = 0;
  endtask

  task automatic drive_random(input int pct);
    int r;
    pipe_we = ($urandom_range(0, 99) < pct);
    pipe_rd = 5'($urandom_range(0, 7));
    pipe_wdata = $urandom;
    r = $urandom_range(0, 7);
    issue_rd = 5'(r);
    issue_valid = ($urandom_range(0, 2) == 0) && (mout < MAXO) && !bz(r);
    if (!held) begin
      if ((pend.size() > 0) && ($urandom_range(0, 1) == 1)) begin
        late_valid = 1; late_rd = 5'(pend[0]); late_wdata = $urandom;
      end else begin
        late_valid = 0;
      end
    end
    rs1_d = 5'($urandom_range(0, 7));
    rs2_d = 5'($urandom_range(0, 7));
    rd_d  = 5'($urandom_range(0, 7));
    regwrite_d = 1'($urandom_range(0, 1));
  endtask

  initial begin
    model_reset();
    held = 0; acc = 0;
    idle();
    start = 0;
    step(); step();
    check("rst_ready", late_ready, 1'b1);
    start = 1;
    step();

    // Dependence on a late write, then commit of 0x1234 to x5.
    issue(5);
    rs1_d = 5; step(); step();
    send_late(32'h0000_1234, 4);
    step(); step(); step();
    rs1_d = 0;

    // W stage wins over buffer head; x7 drains once W goes idle.
    issue(7);
    pipe_we = 1; pipe_rd = 3; pipe_wdata = 32'h0000_aaaa;
    send_late(32'h0000_7777, 4);
    step();
    pipe_we = 0; step(); step();

    // Starvation: W stage holds the port for 10 cycles.
    issue(9);
    pipe_we = 1; pipe_rd = 4; pipe_wdata = 32'h0000_4444;
    send_late(32'h0000_9999, 4);
    repeat (10) step();
    pipe_we = 0; step(); step();

    // Outstanding limit.
    issue(1); issue(2); issue(3); issue(4);
    check("oc_max", out_count, 3'd4);
    check("blk_max", issue_block, 1'b1);
    send_late(32'h1111_0001, 4);
    step(); step();

    // Fill the buffer with W busy; third result must wait, then drain.
    pipe_we = 1; pipe_rd = 6; pipe_wdata = 32'h0000_6666;
    send_late(32'h2222_0002, 4);
    send_late(32'h3333_0003, 4);
    check("full_ready", late_ready, 1'b0);
    late_valid = 1; late_rd = 5'(pend[0]); late_wdata = 32'h4444_0004;
    repeat (3) step();
    check("held_not_taken", acc, 1'b0);
    pipe_we = 0;
    for (int n = 0; n < 6; n++) begin
      step();
      if (acc) break;
    end
    check("held_taken", acc, 1'b1);
    late_valid = 0;
    repeat (3) step();

    // Issue to x0 never marks busy.
    issue(0);
    rs1_d = 0; step();
    send_late(32'h0000_0bad, 4);
    step(); step();

    // Reset in the middle of activity.
    issue(10); issue(11);
    pipe_we = 1; pipe_rd = 2; pipe_wdata = 32'h0000_2222;
    send_late(32'h0000_1010, 4);
    start = 0;
    #1;
    check("mid_rst_we", rf_we, 1'b0);
    check("mid_rst_oc", out_count, 3'd0);
    check("mid_rst_ready", late_ready, 1'b1);
    check("mid_rst_stall", stall_req, 1'b0);
    step();
    idle();
    start = 1;
    held = 0;
    step();

    // Randomized traffic: moderate, then heavy W-stage pressure.
    for (int i = 0; i < 500; i++) begin
      drive_random((i < 250) ? 50 : 90);
      step();
    end
    idle();
    held = 0;
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Owns the single regfile write port and shares it between two requesters: the in-order W-stage writeback and a late-completion channel for long-latency units (divider, multi-cycle loads).
- Keeps a per-register busy scoreboard for outstanding late writes.
- Raises a stall request to the hazard unit when a decoding instruction depends on a busy register, or when late results cannot drain.

Parameters:
- FIFO_DEPTH, 2, entries in the late-result buffer (power of 2, >=2).
- MAX_OUT, 4, maximum outstanding late operations.
- STARVE_LIMIT, 8, cycles a non-empty buffer may be blocked before a forced stall.

Ports:
- clk  input  1  core clock, rising edge
- start  input  1  asynchronous active-low reset (low = reset)
- pipe_we  input  1  W-stage regwrite, already qualified by kill
- pipe_rd  input  5  W-stage destination
- pipe_wdata  input  32  W-stage result
- issue_valid  input  1  long-latency op accepted in EX this cycle
- issue_rd  input  5  its destination
- late_valid  input  1  late unit presents a result
- late_rd  input  5  late result destination
- late_wdata  input  32  late result data
- late_ready  output  1  buffer can accept a late result
- rs1_d  input  5  decode source 1
- rs2_d  input  5  decode source 2
- rd_d  input  5  decode destination
- regwrite_d  input  1  decode instruction writes rd
- rf_we  output  1  regfile write enable
- rf_waddr  output  5  regfile write address
- rf_wdata  output  32  regfile write data
- stall_req  output  1  to hazard unit: stall F/D
- issue_block  output  1  to hazard unit: do not issue further long-latency ops
- out_count  output  3  outstanding late ops (issued, not committed)

Behaviour:
- Reset (start low, async): busy[31:0]=0, FIFO empty, out_count=0, starve counter=0, rf_we=0, stall_req=0, issue_block=0, late_ready=1.
- Busy set:
  - issue_valid with issue_rd!=0 sets busy[issue_rd] and increments out_count at the next edge.
  - issue_rd==0 still counts in out_count but sets no busy bit.
- Late accept: the handshake late_valid&&late_ready pushes {late_rd, late_wdata}. late_ready = !full.
- Port arbitration, combinational each cycle:
  - If pipe_we && pipe_rd!=0, the W stage owns the port: rf_we=1, rf_waddr=pipe_rd, rf_wdata=pipe_wdata.
  - Otherwise, if the FIFO is non-empty, pop the head: rf_we=1, addr/data from the head.
  - Otherwise rf_we=0.
- Commit:
  - A FIFO pop clears busy[rd] and decrements out_count at the same edge.
  - A simultaneous issue to the same rd leaves busy set.
  - A simultaneous issue and commit leaves out_count unchanged.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and the pop is blocked by the W stage.
  - Clears on a pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- stall_req is asserted combinationally when any of these hold:
  - rs1_d!=0 && busy[rs1_d]
  - rs2_d!=0 && busy[rs2_d]
  - regwrite_d && rd_d!=0 && busy[rd_d] (WAW)
  - FIFO full
  - starve counter == STARVE_LIMIT
- issue_block = (out_count==MAX_OUT) || (issue_valid && issue_rd busy). The second term is an illegal condition: assertion fires, and the issue is still recorded.
- Data forwarding from the FIFO to decode is not provided. A dependent instruction stalls until commit, then reads the regfile (write-before-read inside the regfile).
- Boundaries:
  - Push and pop in the same cycle while full is allowed only if the pop happens. late_ready stays low while full; no lookahead.
  - Pointers wrap modulo FIFO_DEPTH.
  - Overflow of out_count is an assertion failure.
  - Reset mid-operation discards all buffered results and busy bits.

Optional Feature:
- Macro WB_BYPASS_EN.
- When defined: if the FIFO is empty, the W stage is not writing, and late_valid is high, the late result writes the regfile in the same cycle without entering the FIFO. busy and out_count update as a pop.
- When undefined: every late result passes through the FIFO, so the minimum accept-to-write latency is 1 cycle.

Decomposition:
- riscv_defines gains wb_entry_t {logic [4:0] rd; logic [31:0] wdata;} and the default constants for FIFO_DEPTH/MAX_OUT/STARVE_LIMIT.
- One sub-module, wb_fifo: parameterised sync FIFO of wb_entry_t with push/pop/full/empty and async active-low reset.

Test Plan:
- Issue rd=5, then decode rs1=5 → stall_req=1 each cycle. Late result rd=5 data 0x1234 while pipe_we=0 → rf_we=1, rf_waddr=5, rf_wdata=0x1234 the next cycle (same cycle with WB_BYPASS_EN); stall_req drops the cycle after commit.
- pipe_we=1 rd=3 and a FIFO head rd=7 in the same cycle → regfile writes x3. x7 is written on the first cycle with pipe_we=0.
- pipe_we held 1 for 10 cycles with a non-empty FIFO → stall_req=1 from cycle 8 (STARVE_LIMIT=8) until the pop occurs.
- Issue 4 ops to rd=1..4 → out_count=4, issue_block=1. One commit → out_count=3, issue_block=0.
- Two late results with no drain, depth 2 → late_ready=0 and stall_req=1. A third late_valid is held by the producer; nothing is lost.
- Issue to rd=0 → busy unchanged, decode rs1=0 not stalled. Assert start low mid-operation → FIFO empty, out_count=0, rf_we=0 immediately.
